// File: rtl/seq_pkg.sv
// Shared types for the multi-cycle instruction sequencer: FSM states,
// instruction classes, opcode encodings and fault codes.
package seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_e;

   typedef enum logic [2:0] {
      C_R   = 3'd0,
      C_I   = 3'd1,
      C_LD  = 3'd2,
      C_SD  = 3'd3,
      C_BEQ = 3'd4,
      C_ILL = 3'd5
   } iclass_e;

   typedef enum logic [1:0] {
      F_NONE    = 2'b00,
      F_ILLEGAL = 2'b01,
      F_IMEM_TO = 2'b10,
      F_DMEM_TO = 2'b11
   } fault_e;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   function automatic iclass_e classify(input logic [6:0] op);
      iclass_e cls;
      case (op)
         OP_R:    cls = C_R;
         OP_I:    cls = C_I;
         OP_LD:   cls = C_LD;
         OP_SD:   cls = C_SD;
         OP_BEQ:  cls = C_BEQ;
         default: cls = C_ILL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Maps the 7-bit major opcode of the latched IR onto an instruction class.
module opcode_decoder
   import seq_pkg::*;
(
   input  logic [6:0] opcode_i,
   output iclass_e    cls_o,
   output logic       legal_o
);

   assign cls_o   = classify(opcode_i);
   assign legal_o = (cls_o != C_ILL);

endmodule

// File: rtl/wait_timer.sv
// Counts consecutive not-ready cycles of a memory handshake and flags the
// cycle on which the TIMEOUT-th miss occurs.
module wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic active_i,
   input  logic ready_i,
   output logic expired_o
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // The counter holds misses seen so far; any non-waiting cycle or a ready
   // clears it, so every FETCH/MEM visit starts from zero.
   always_comb begin
      cnt_d = '0;
      if (active_i && !ready_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // A ready on the final allowed cycle wins over the timeout.
   assign expired_o = active_i && !ready_i && (cnt_q == LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshake timeouts, sticky HALT on faults and a retired-instruction counter.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [6:0]       opcode,
   input  logic             zero,
   output logic             imem_req,
   input  logic             imem_ready,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ready,
   output logic             ir_we,
   output logic             mdr_we,
   output logic             rf_we,
   output logic             pc_we,
   output logic             pc_sel,
   output logic             halted,
   output logic [1:0]       fault,
   output logic [CNT_W-1:0] instret
);

   state_e           state_q;
   iclass_e          cls_q;
   fault_e           fault_q;
   logic             halted_q;
   logic [CNT_W-1:0] instret_q;

   iclass_e dec_cls;
   logic    dec_legal;
   logic    in_fetch, in_mem, in_exec, in_wb;
   logic    wait_active, wait_ready, wait_expired;

   opcode_decoder u_dec (
      .opcode_i (opcode),
      .cls_o    (dec_cls),
      .legal_o  (dec_legal)
   );

   assign in_fetch    = (state_q == S_FETCH);
   assign in_mem      = (state_q == S_MEM);
   assign in_exec     = (state_q == S_EXEC);
   assign in_wb       = (state_q == S_WB);
   assign wait_active = in_fetch || in_mem;
   assign wait_ready  = in_fetch ? imem_ready : dmem_ready;

   wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .active_i  (wait_active),
      .ready_i   (wait_ready),
      .expired_o (wait_expired)
   );

   // Strobes that accompany a handshake are qualified by the ready of the
   // current cycle so the datapath captures data while it is valid.
   assign imem_req = in_fetch;
   assign ir_we    = in_fetch && imem_ready;
   assign dmem_req = in_mem;
   assign dmem_we  = in_mem && (cls_q == C_SD);
   assign mdr_we   = in_mem && dmem_ready && (cls_q == C_LD);
   assign rf_we    = in_wb;
   assign pc_we    = in_wb
                  || (in_exec && (cls_q == C_BEQ))
                  || (in_mem && dmem_ready && (cls_q == C_SD));
   assign pc_sel   = in_exec && (cls_q == C_BEQ) && zero;
   assign halted   = halted_q;
   assign fault    = fault_q;
   assign instret  = instret_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cls_q     <= C_ILL;
         fault_q   <= F_NONE;
         halted_q  <= 1'b0;
         instret_q <= '0;
      end else begin
         if (pc_we) begin
            instret_q <= instret_q + 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (imem_ready) begin
                  state_q <= S_DECODE;
               end else if (wait_expired) begin
                  state_q  <= S_HALT;
                  fault_q  <= F_IMEM_TO;
                  halted_q <= 1'b1;
               end
            end
            S_DECODE: begin
               if (dec_legal) begin
                  cls_q   <= dec_cls;
                  state_q <= S_EXEC;
               end else begin
                  state_q  <= S_HALT;
                  fault_q  <= F_ILLEGAL;
                  halted_q <= 1'b1;
               end
            end
            S_EXEC: begin
               case (cls_q)
                  C_R, C_I:   state_q <= S_WB;
                  C_LD, C_SD: state_q <= S_MEM;
                  C_BEQ:      state_q <= S_FETCH;
                  default: begin
                     state_q  <= S_HALT;
                     fault_q  <= F_ILLEGAL;
                     halted_q <= 1'b1;
                  end
               endcase
            end
            S_MEM: begin
               if (dmem_ready) begin
                  state_q <= (cls_q == C_LD) ? S_WB : S_FETCH;
               end else if (wait_expired) begin
                  state_q  <= S_HALT;
                  fault_q  <= F_DMEM_TO;
                  halted_q <= 1'b1;
               end
            end
            S_WB: begin
               state_q <= S_FETCH;
            end
            S_HALT: begin
               state_q <= S_HALT;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: expected strobe events are queued as
// each instruction is driven and matched cycle-by-cycle against the DUT.
module tb_instr_sequencer;

   localparam int TO = 16;
   localparam logic [6:0] OPR   = 7'b0110011;
   localparam logic [6:0] OPI   = 7'b0010011;
   localparam logic [6:0] OPLD  = 7'b0000011;
   localparam logic [6:0] OPSD  = 7'b0100011;
   localparam logic [6:0] OPBEQ = 7'b1100011;
   localparam logic [6:0] OPILL = 7'b1111111;
   localparam logic [3:0] W_IR  = 4'b1000;
   localparam logic [3:0] W_MDR = 4'b0100;
   localparam logic [3:0] W_RF  = 4'b0010;
   localparam logic [3:0] W_PC  = 4'b0001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [6:0]  opcode = 7'd0;
   logic        zero = 1'b0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        imem_req, dmem_req, dmem_we;
   logic        ir_we, mdr_we, rf_we, pc_we, pc_sel, halted;
   logic [1:0]  fault;
   logic [31:0] instret;

   always #5 clk = ~clk;

   instr_sequencer #(.TIMEOUT(TO), .CNT_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .opcode     (opcode),
      .zero       (zero),
      .imem_req   (imem_req),
      .imem_ready (imem_ready),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_ready (dmem_ready),
      .ir_we      (ir_we),
      .mdr_we     (mdr_we),
      .rf_we      (rf_we),
      .pc_we      (pc_we),
      .pc_sel     (pc_sel),
      .halted     (halted),
      .fault      (fault),
      .instret    (instret)
   );

   typedef struct {
      int          cyc;
      logic [3:0]  we;
      logic        sel;
      logic [31:0] iret;
   } ev_t;

   ev_t sb[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  exp_iret = 0;
   int  n_dreq = 0;
   int  n_dwe = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] we, input logic sel);
      ev_t e;
      e.cyc  = cyc;
      e.we   = we;
      e.sel  = sel;
      e.iret = 32'(exp_iret);
      sb.push_back(e);
   endtask

   // Mid-cycle sample: every write-enable cycle must match the queue head.
   task automatic half();
      logic [3:0] w;
      ev_t        e;
      @(negedge clk);
      w = {ir_we, mdr_we, rf_we, pc_we};
      if (dmem_req) n_dreq++;
      if (dmem_we) n_dwe++;
      if (w != 4'b0000) begin
         if (sb.size() == 0) begin
            check("unexpected_strobe", {60'd0, w}, 64'd0);
         end else begin
            e = sb.pop_front();
            check("sb_event", {cyc[15:0], w, pc_sel, instret},
                  {e.cyc[15:0], e.we, e.sel, e.iret});
         end
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic tick();
      half();
      next();
   endtask

   function automatic bit legal(input logic [6:0] op);
      return (op == OPR) || (op == OPI) || (op == OPLD) || (op == OPSD) || (op == OPBEQ);
   endfunction

   // Entered with the DUT in FETCH; returns in the following FETCH, or in HALT
   // when a fault is provoked (illegal opcode, iwait/dwait >= TO).
   task automatic instr(input logic [6:0] op, input int iwait, input int dwait, input logic z);
      opcode = op;
      zero = 1'b1;
      dmem_ready = 1'b1;
      for (int k = 0; k < iwait && k < TO; k++) begin
         imem_ready = 1'b0;
         half();
         if (iwait >= TO && k == TO - 1) check("imem_last_wait", {imem_req, halted, ir_we}, 3'b100);
         next();
      end
      if (iwait >= TO) return;
      imem_ready = 1'b1;
      push(W_IR, 1'b0);
      tick();
      tick();
      if (!legal(op)) return;
      if (op == OPBEQ) begin
         zero = z;
         push(W_PC, z);
         tick();
         zero = 1'b1;
         exp_iret++;
         return;
      end
      if (op == OPR || op == OPI) begin
         tick();
         push(W_RF | W_PC, 1'b0);
         tick();
         exp_iret++;
         return;
      end
      tick();
      for (int k = 0; k < dwait && k < TO; k++) begin
         dmem_ready = 1'b0;
         half();
         if (dwait >= TO && k == TO - 1) check("dmem_last_wait", {dmem_req, halted}, 2'b10);
         next();
      end
      if (dwait >= TO) return;
      dmem_ready = 1'b1;
      if (op == OPLD) begin
         push(W_MDR, 1'b0);
         tick();
         push(W_RF | W_PC, 1'b0);
         tick();
      end else begin
         push(W_PC, 1'b0);
         tick();
      end
      exp_iret++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      half();
      check("reset_state", {imem_req, dmem_req, dmem_we, ir_we, mdr_we, rf_we, pc_we,
                            pc_sel, halted, fault, instret}, 64'd0);
      rst_n = 1'b1;
      exp_iret = 0;
      next();
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int d0, w0;
      do_reset();

      // Readies high while idle must not start anything.
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      zero = 1'b1;
      repeat (3) tick();
      half();
      check("idle_no_req", {imem_req, dmem_req, halted}, 3'b000);
      next();

      go();
      instr(OPR, 0, 0, 1'b0);
      d0 = n_dreq; w0 = n_dwe;
      instr(OPLD, 0, 3, 1'b0);
      check("ld_dmem_req_cycles", 64'(n_dreq - d0), 64'd4);
      check("ld_dmem_we_cycles", 64'(n_dwe - w0), 64'd0);
      instr(OPI, 2, 0, 1'b0);
      d0 = n_dreq; w0 = n_dwe;
      instr(OPSD, 0, 1, 1'b0);
      check("sd_dmem_req_cycles", 64'(n_dreq - d0), 64'd2);
      check("sd_dmem_we_cycles", 64'(n_dwe - w0), 64'd2);
      instr(OPBEQ, 0, 0, 1'b1);
      instr(OPBEQ, 0, 0, 1'b0);
      instr(OPR, TO - 1, 0, 1'b0);
      instr(OPR, TO, 0, 1'b0);
      half();
      check("imem_timeout", {halted, fault, imem_req, instret}, {1'b1, 2'b10, 1'b0, 32'(exp_iret)});
      check("instret_total", 64'(instret), 64'd7);
      next();
      start = 1'b1;
      repeat (3) tick();
      start = 1'b0;
      half();
      check("halt_sticky_imem", {halted, fault, imem_req, dmem_req}, {1'b1, 2'b10, 1'b0, 1'b0});
      next();

      do_reset();
      go();
      instr(OPR, 0, 0, 1'b0);
      instr(OPILL, 0, 0, 1'b0);
      half();
      check("illegal_halt", {halted, fault, instret}, {1'b1, 2'b01, 32'd1});
      next();
      start = 1'b1;
      repeat (3) tick();
      start = 1'b0;
      half();
      check("illegal_sticky", {halted, fault, imem_req, instret}, {1'b1, 2'b01, 1'b0, 32'd1});
      next();

      do_reset();
      go();
      instr(OPLD, 0, 0, 1'b0);
      instr(OPSD, 0, TO, 1'b0);
      half();
      check("dmem_timeout", {halted, fault, dmem_req, dmem_we, instret},
            {1'b1, 2'b11, 1'b0, 1'b0, 32'd1});
      next();

      do_reset();
      go();
      instr(OPSD, 0, 0, 1'b0);
      opcode = OPSD;
      imem_ready = 1'b1;
      push(W_IR, 1'b0);
      tick();
      tick();
      tick();
      dmem_ready = 1'b0;
      half();
      check("sd_mem_req", {dmem_req, dmem_we, instret}, {1'b1, 1'b1, 32'd1});
      #2 rst_n = 1'b0;
      #1;
      check("reset_mid_mem", {dmem_req, dmem_we, imem_req, ir_we, mdr_we, rf_we, pc_we, instret}, 64'd0);
      exp_iret = 0;
      next();
      tick();
      rst_n = 1'b1;
      half();
      check("idle_after_reset", {imem_req, dmem_req, halted, fault, instret}, 64'd0);
      next();
      go();
      instr(OPR, 0, 0, 1'b0);
      instr(OPR, TO, 0, 1'b0);
      half();
      check("restart_after_reset", {halted, fault, instret}, {1'b1, 2'b10, 32'd1});
      next();

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max cycles to wait for any memory ready before faulting.
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of the retired-instruction counter.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  leave IDLE and begin fetching.
REQ-006 SHALL have port opcode  input  7  instruction[6:0] of the latched IR.
REQ-007 SHALL have port zero  input  1  ALU result == 0, for beq.
REQ-008 SHALL have port imem_req  output  1  instruction fetch request.
REQ-009 SHALL have port imem_ready  input  1  fetch data valid this cycle.
REQ-010 SHALL have port dmem_req  output  1  data memory request.
REQ-011 SHALL have port dmem_we  output  1  data request is a store (sd).
REQ-012 SHALL have port dmem_ready  input  1  data access done; load data valid this cycle.
REQ-013 SHALL have ports ir_we, mdr_we, rf_we, pc_we  output  1 each  IR, load-data, register-file and PC write enables.
REQ-014 SHALL have port pc_sel  output  1  0 = PC+4, 1 = branch target.
REQ-015 SHALL have port halted  output  1  sequencer stopped in HALT.
REQ-016 SHALL have port fault  output  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.
REQ-017 SHALL have port instret  output  CNT_W  retired-instruction count.

Function
REQ-018 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; all outputs registered or decoded from state only.
REQ-019 IDLE: SHALL move to FETCH on start=1; start SHALL be ignored in every other state.
REQ-020 FETCH: SHALL hold imem_req=1 until imem_ready=1; on that cycle ir_we=1 (one pulse) and next state DECODE.
REQ-021 DECODE: SHALL classify opcode: 0110011 R, 0010011 I, 0000011 ld, 0100011 sd, 1100011 beq; other -> HALT, fault=01, no PC/RF write.
REQ-022 EXEC: R/I -> WB; ld/sd -> MEM; beq -> pc_we=1, pc_sel=zero, next FETCH.
REQ-023 MEM: SHALL hold dmem_req=1, dmem_we=1 only for sd, until dmem_ready=1; ld -> mdr_we=1 then WB; sd -> pc_we=1, pc_sel=0, next FETCH.
REQ-024 WB: SHALL assert rf_we=1 and pc_we=1, pc_sel=0 for one cycle, next FETCH.
REQ-025 Latency with ready already high: beq 3, R/I/sd 4, ld 5 cycles per instruction.
REQ-026 rf_we SHALL never be asserted for sd or beq; dmem_req SHALL never be asserted for R/I/beq.
REQ-027 Wait counter SHALL clear on entering FETCH/MEM, increment each not-ready cycle; reaching TIMEOUT -> HALT, fault=10 (FETCH) or 11 (MEM), no write enables that cycle.
REQ-028 Ready arriving on the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-029 instret SHALL increment by 1 on every pc_we=1 cycle and wrap modulo 2^CNT_W.
REQ-030 HALT SHALL be sticky until rst_n; halted=1, all request/enable outputs 0, fault held.
REQ-031 Ready inputs outside FETCH/MEM SHALL be ignored.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state=IDLE, instret=0, fault=00, wait counter=0, all request/enable outputs and halted to 0.
REQ-033 Reset mid-request SHALL drop imem_req/dmem_req in the same cycle without any write enable pulse.
REQ-034 Deassertion SHALL leave the sequencer in IDLE awaiting start.

Structure
REQ-035 State enum, opcode constants and fault codes SHALL live in shared package seq_pkg, reused by the opcode decoder.
REQ-036 Wait counter with timeout compare SHALL be one sub-module, wait_timer.

Verification
REQ-037 R-type 0110011, ready tied high, start pulse -> ir_we at cycle 1, rf_we+pc_we at cycle 4, instret=1.
REQ-038 ld with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, mdr_we then rf_we, 8 cycles total.
REQ-039 beq with zero=1 then zero=0 -> pc_sel=1 then 0, pc_we at cycle 3, rf_we never asserted.
REQ-040 opcode 1111111 -> HALT, fault=01, halted=1, instret unchanged, start ignored until rst_n.
REQ-041 imem_ready held 0 -> HALT after 16 cycles, fault=10; ready on cycle 16 instead -> normal DECODE.
REQ-042 rst_n low during MEM of sd -> dmem_req=0 immediately, IDLE, instret=0, no pc_we.
